counter_sweep_ctrl: RTL and testbench
=====================================

Name: counter_sweep_ctrl

Overview:
Controller that sequences the 8-bit cascaded up/down counter datapath: it drives the counter's carry-in enable (cin) and updown, and observes its q output. It performs a programmed number of triangular sweeps between a low and a high limit, then reports completion. The counter has no reset or load, so the controller first seeks the counter from any start value to the low limit.

Parameters:
W, 8, counter width; must match the counter datapath q width.
SW, 4, width of the sweep-count field.

Ports:
clock  in  1  system clock; rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  begin a run; sampled only in IDLE.
abort  in  1  terminate the run; sampled in SEEK/UP/DOWN.
hold  in  1  pause; forces cnt_en=0 and freezes state.
lo_lim  in  W  low sweep limit; latched on accepted start.
hi_lim  in  W  high sweep limit; latched on accepted start.
sweeps  in  SW  number of sweeps; 0 = run until abort; latched on accepted start.
q_in  in  W  counter datapath q (feedback).
cnt_en  out  1  to counter cin.
cnt_up  out  1  to counter updown (1 = up).
busy  out  1  high in SEEK, UP and DOWN.
done  out  1  one-cycle pulse on completion.
err  out  1  one-cycle pulse when start is rejected for illegal limits.
sweep_cnt  out  SW  completed sweeps in the current run.

Behaviour:
- Reset, asynchronous: state=IDLE; lo_r, hi_r, sweeps_r and sweep_cnt = 0; done=0; err=0; busy=0. Consequently cnt_en=0 and cnt_up=1. Reset mid-run leaves the counter at an arbitrary value; the next run's SEEK recovers it.
- States: IDLE, SEEK, UP, DOWN, DONE. State, limits, sweep_cnt, done and err are registered.
- cnt_en and cnt_up are combinational from state, q_in, the latched limits and hold:
  - IDLE, DONE: en=0, up=1.
  - SEEK: en=(q_in!=lo_r)&~hold&~abort; up=(q_in<lo_r), unsigned compare.
  - UP: en=(q_in!=hi_r)&~hold&~abort; up=1.
  - DOWN: en=(q_in!=lo_r)&~hold&~abort; up=0.
- The counter updates on the edge where cnt_en=1. The controller never enables past a limit, so the counter never wraps.
- IDLE, start=1:
  - lo_lim>=hi_lim: err pulses next cycle; stay IDLE; limits not latched.
  - Otherwise: latch lo_r, hi_r and sweeps_r; clear sweep_cnt; go to SEEK.
- SEEK: when q_in==lo_r (and hold=0), go to UP.
- UP: when q_in==hi_r (and hold=0), go to DOWN.
- DOWN: when q_in==lo_r (and hold=0):
  - sweep_cnt increments, wrapping mod 2^SW.
  - If sweeps_r!=0 and sweep_cnt+1==sweeps_r, go to DONE; otherwise go to UP.
- DONE: lasts one cycle with done=1, then IDLE.
- Each turnaround costs one non-counting cycle. A sweep therefore takes 2*(hi-lo)+2 cycles when hold=0.
- hold=1 in any active state: state and sweep_cnt freeze and cnt_en=0.
- abort=1 in SEEK/UP/DOWN: cnt_en=0 that cycle; IDLE next cycle; no done. sweep_cnt keeps its value until the next start.
- Simultaneous abort and hold: abort wins.
- Simultaneous abort and limit reached: abort wins.
- start while busy: ignored. Limit inputs may change freely while busy because only the latched values are used.
- busy is derived from the registered state and is asserted from the cycle after start through the last DOWN cycle.

Test Plan:
1. Reset with q_in=0x55 → cnt_en=0, cnt_up=1, busy=0, done=0, err=0, sweep_cnt=0; hold reset 3 cycles and confirm nothing changes.
2. Counter model at q=10; start with lo=4, hi=8, sweeps=1 → SEEK gives 6 down-enables (q reaches 4) plus 1 idle cycle; UP gives 4 enables plus 1 idle; DOWN gives 4 enables plus 1 idle; done pulses once with sweep_cnt=1; total 18 cycles from the start edge to the done edge, then IDLE.
3. q=4; start with lo=4, hi=6, sweeps=3 → SEEK exits after 1 cycle; q traces 4,5,6,6,5,4,4,5… for three sweeps; sweep_cnt steps 1,2,3; done asserts exactly once.
4. start with lo=9, hi=9 → err=1 for one cycle, busy stays 0, cnt_en stays 0; repeat with lo=9, hi=3 and get the same result.
5. In UP at q=6 (lo=2, hi=9), assert hold for 5 cycles → q stays 6 and cnt_en=0; release and counting resumes up. Then assert abort in DOWN → cnt_en=0 in the abort cycle, IDLE next cycle, no done.
6. sweeps=0 with lo=0, hi=1 → continuous sweeping with sweep_cnt wrapping 15→0; start pulses during the run are ignored; abort ends the run; assert reset mid-UP → IDLE immediately with cnt_en=0.

Source files
------------

// File: rtl/counter_sweep_ctrl_if.sv
// Bundle between the sweep controller and its environment:
// run control, limits, counter feedback/drive and status.
interface counter_sweep_ctrl_if #(
  parameter int W  = 8,
  parameter int SW = 4
);
  logic          start;
  logic          abort;
  logic          hold;
  logic [W-1:0]  lo_lim;
  logic [W-1:0]  hi_lim;
  logic [SW-1:0] sweeps;
  logic [W-1:0]  q_in;
  logic          cnt_en;
  logic          cnt_up;
  logic          busy;
  logic          done;
  logic          err;
  logic [SW-1:0] sweep_cnt;

  modport master (
    output start, abort, hold,
    output lo_lim, hi_lim, sweeps, q_in,
    input  cnt_en, cnt_up, busy,
    input  done, err, sweep_cnt
  );

  modport slave (
    input  start, abort, hold,
    input  lo_lim, hi_lim, sweeps, q_in,
    output cnt_en, cnt_up, busy,
    output done, err, sweep_cnt
  );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// Sequences a free-running up/down counter through
// triangular sweeps between latched low/high limits.
module counter_sweep_ctrl #(
  parameter int W  = 8,
  parameter int SW = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  counter_sweep_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE, SEEK, UP, DOWN, DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_hi;
  logic [SW-1:0] r_sweeps;
  logic [SW-1:0] r_sweep_cnt;
  logic          r_done;
  logic          r_err;

  logic          w_at_lo;
  logic          w_at_hi;
  logic          w_bad;
  logic          w_accept;
  logic          w_reject;
  logic          w_inc;
  logic          w_en;
  logic          w_up;
  logic [SW-1:0] w_cnt_inc;

  assign w_at_lo   = (bus.q_in == r_lo);
  assign w_at_hi   = (bus.q_in == r_hi);
  assign w_bad     = (bus.lo_lim >= bus.hi_lim);
  assign w_accept  = (r_state == IDLE) & bus.start & ~w_bad;
  assign w_reject  = (r_state == IDLE) & bus.start & w_bad;
  assign w_cnt_inc = r_sweep_cnt + SW'(1);

  // Next state and counter drive; abort beats hold and limit hits
  always_comb begin
    w_next = r_state;
    w_en   = 1'b0;
    w_up   = 1'b1;
    w_inc  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next = SEEK;
      end
      SEEK: begin
        w_up = (bus.q_in < r_lo);
        if (bus.abort) begin
          w_next = IDLE;
        end else if (!bus.hold) begin
          w_en = ~w_at_lo;
          if (w_at_lo) w_next = UP;
        end
      end
      UP: begin
        if (bus.abort) begin
          w_next = IDLE;
        end else if (!bus.hold) begin
          w_en = ~w_at_hi;
          if (w_at_hi) w_next = DOWN;
        end
      end
      DOWN: begin
        w_up = 1'b0;
        if (bus.abort) begin
          w_next = IDLE;
        end else if (!bus.hold) begin
          w_en = ~w_at_lo;
          if (w_at_lo) begin
            w_inc = 1'b1;
            if (r_sweeps != '0 && w_cnt_inc == r_sweeps)
              w_next = DONE;
            else
              w_next = UP;
          end
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State, latched run parameters, sweep count and status pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lo        <= '0;
      r_hi        <= '0;
      r_sweeps    <= '0;
      r_sweep_cnt <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == DONE);
      r_err   <= w_reject;
      if (w_accept) begin
        r_lo        <= bus.lo_lim;
        r_hi        <= bus.hi_lim;
        r_sweeps    <= bus.sweeps;
        r_sweep_cnt <= '0;
      end else if (w_inc) begin
        r_sweep_cnt <= w_cnt_inc;
      end
    end
  end

  assign bus.cnt_en    = w_en;
  assign bus.cnt_up    = w_up;
  assign bus.busy      = (r_state == SEEK) |
                         (r_state == UP) |
                         (r_state == DOWN);
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.sweep_cnt = r_sweep_cnt;
endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: counter datapath model plus
// a position-vs-time reference of the sweep trajectory.
module tb_counter_sweep_ctrl;
  localparam int W  = 8;
  localparam int SW = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  counter_sweep_ctrl_if #(.W(W), .SW(SW)) bus ();

  counter_sweep_ctrl #(.W(W), .SW(SW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [W-1:0] q;
  logic         ld;
  logic [W-1:0] ld_val;

  // Cascaded counter datapath: no reset, bench-side load only
  always_ff @(posedge clock) begin
    if (ld)
      q <= ld_val;
    else if (bus.cnt_en)
      q <= bus.cnt_up ? q + 8'd1 : q - 8'd1;
  end

  assign bus.q_in = q;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  bit m_active;
  bit m_err;
  int m_scnt;
  int k, q0, lo, hi, nsw;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Position along the run as a function of active cycles k:
  // seek leg of |q0-lo| steps + turnaround, then periods of
  // 2L+2 cycles (L up steps, turn, L down steps, turn).
  function automatic void model(output int ph, output int pq,
                                output bit en, output bit up,
                                output int sc);
    int d, l, p, j, s, mm;
    d = (q0 > lo) ? q0 - lo : lo - q0;
    l = hi - lo;
    p = 2 * l + 2;
    if (k <= d) begin
      ph = 0;
      pq = (q0 > lo) ? q0 - k : q0 + k;
      en = (k < d);
      up = (pq < lo);
      sc = 0;
    end else begin
      j = k - d - 1;
      s = j / p;
      mm = j % p;
      sc = s % 16;
      if (nsw != 0 && s == nsw) begin
        ph = 3; pq = lo; en = 0; up = 1;
      end else if (mm <= l) begin
        ph = 1; pq = lo + mm; en = (mm < l); up = 1;
      end else begin
        ph = 2; pq = hi - (mm - l - 1);
        en = (mm < 2 * l + 1); up = 0;
      end
    end
  endfunction

  task automatic idle_step(input bit s);
    @(negedge clock);
    bus.hold = 0;
    bus.abort = 0;
    bus.start = s;
    #1;
    chk("idle_en", bus.cnt_en, 0);
    chk("idle_up", bus.cnt_up, 1);
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.done, 0);
    chk("idle_err", bus.err, m_err);
    chk("idle_scnt", bus.sweep_cnt, m_scnt);
    m_err = 0;
  endtask

  task automatic do_start(input int l_, input int h_, input int s_);
    bus.lo_lim = l_[7:0];
    bus.hi_lim = h_[7:0];
    bus.sweeps = s_[3:0];
    idle_step(1);
    if (l_ >= h_) begin
      m_err = 1;
    end else begin
      m_active = 1;
      k = 0;
      q0 = q;
      lo = l_;
      hi = h_;
      nsw = s_;
      m_scnt = 0;
    end
  endtask

  task automatic step(input bit h, input bit a, input bit s);
    int ph, pq, sc;
    bit en, up;
    @(negedge clock);
    bus.hold = h;
    bus.abort = a;
    bus.start = s;
    bus.lo_lim = 8'($urandom);
    bus.hi_lim = 8'($urandom);
    bus.sweeps = 4'($urandom);
    #1;
    model(ph, pq, en, up, sc);
    if (ph == 3) begin
      chk("done_pulse", bus.done, 1);
      chk("done_busy", bus.busy, 0);
      chk("done_en", bus.cnt_en, 0);
      chk("done_up", bus.cnt_up, 1);
    end else begin
      chk("run_done", bus.done, 0);
      chk("run_busy", bus.busy, 1);
      chk("run_en", bus.cnt_en, en & ~h & ~a);
      chk("run_up", bus.cnt_up, up);
    end
    chk("run_q", q, pq);
    chk("run_scnt", bus.sweep_cnt, sc);
    chk("run_err", bus.err, 0);
    if (bus.done) n_done++;
    if (ph == 3 || a) begin
      m_active = 0;
      m_scnt = sc;
    end else if (!h) begin
      k++;
    end
  endtask

  task automatic run_all(input int bound, input bit rnd_hold,
                         output int n);
    n = 0;
    while (m_active && n < bound) begin
      step(rnd_hold && ($urandom_range(0, 3) == 0), 0, 0);
      n++;
    end
    chk("run_timeout", m_active, 0);
  endtask

  function automatic int cur_phase(output int pq);
    int ph, sc;
    bit en, up;
    model(ph, pq, en, up, sc);
    return ph;
  endfunction

  task automatic load(input int v);
    @(negedge clock);
    ld = 1;
    ld_val = v[7:0];
    @(posedge clock);
    #1 ld = 0;
  endtask

  task automatic mid_reset();
    @(negedge clock);
    reset = 1;
    #1;
    chk("mrst_en", bus.cnt_en, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_scnt", bus.sweep_cnt, 0);
    m_active = 0;
    m_scnt = 0;
    m_err = 0;
    @(negedge clock);
    reset = 0;
  endtask

  initial begin
    int n, pq, lr, hr;
    reset = 1;
    ld = 1;
    ld_val = 8'h55;
    bus.start = 0;
    bus.abort = 0;
    bus.hold = 0;
    bus.lo_lim = 0;
    bus.hi_lim = 0;
    bus.sweeps = 0;
    m_active = 0;
    m_err = 0;
    m_scnt = 0;
    @(posedge clock);
    #1 ld = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      chk("rst_en", bus.cnt_en, 0);
      chk("rst_up", bus.cnt_up, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_scnt", bus.sweep_cnt, 0);
      chk("rst_q", q, 8'h55);
    end
    @(negedge clock);
    reset = 0;
    idle_step(0);

    load(10);
    do_start(4, 8, 1);
    n_done = 0;
    run_all(100, 0, n);
    chk("t2_len", n, 18);
    chk("t2_ndone", n_done, 1);
    idle_step(0);

    do_start(4, 6, 3);
    n_done = 0;
    run_all(100, 0, n);
    chk("t3_len", n, 2 + 3 * 6);
    chk("t3_ndone", n_done, 1);
    idle_step(0);
    idle_step(0);

    do_start(9, 9, 1);
    idle_step(0);
    idle_step(0);
    do_start(9, 3, 1);
    idle_step(0);
    idle_step(0);

    do_start(2, 9, 2);
    n = 0;
    while (!(cur_phase(pq) == 1 && pq == 6) && n < 100) begin
      step(0, 0, 0);
      n++;
    end
    chk("t5_reach_up6", n < 100, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    chk("t5_hold_q", q, 6);
    n = 0;
    while (cur_phase(pq) != 2 && n < 100) begin
      step(0, 0, 0);
      n++;
    end
    chk("t5_reach_down", n < 100, 1);
    n_done = 0;
    step(0, 1, 0);
    idle_step(0);
    chk("t5_no_done", n_done, 0);

    do_start(0, 1, 0);
    for (int i = 0; i < 80; i++) step(0, 0, (i % 7) == 3);
    step(0, 1, 0);
    idle_step(0);
    do_start(0, 1, 0);
    n = 0;
    while (cur_phase(pq) != 1 && n < 100) begin
      step(0, 0, 0);
      n++;
    end
    mid_reset();
    idle_step(0);

    for (int r = 0; r < 6; r++) begin
      load($urandom_range(0, 255));
      lr = $urandom_range(0, 200);
      hr = lr + $urandom_range(1, 40);
      do_start(lr, hr, $urandom_range(1, 3));
      n_done = 0;
      run_all(5000, 1, n);
      chk("rnd_ndone", n_done, 1);
      idle_step(0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
